// File: rtl/mcc_adder.sv
// Registered N-bit adder built from 4-bit Manchester carry-chain blocks (last block partial).
// Define MCC_ADDER_OVF_EN to add a registered two's-complement overflow output, ovf.
module mcc_adder #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef MCC_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned NumBlk = (N + 3) / 4;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] k;
  logic [N:0]   c;
  logic [4:0]   node;
  logic         blk_carry;
  logic [N-1:0] sum_next;
  logic         cout_next;

  assign g = a & b;
  assign p = a ^ b;
  assign k = ~a & ~b;

  // Each block ripples its own nodes, then hands its carry-out to the next block.
  // The ~k term models the kill pull-down; it is redundant with p but keeps the cell shape.
  always_comb begin
    c         = '0;
    node      = '0;
    blk_carry = cin;
    c[0]      = cin;
    for (int unsigned blk = 0; blk < NumBlk; blk++) begin
      node    = '0;
      node[0] = blk_carry;
      for (int unsigned j = 0; j < 4; j++) begin
        if (blk * 4 + j < N) begin
          node[j+1]        = g[blk*4+j] | (~k[blk*4+j] & p[blk*4+j] & node[j]);
          c[blk*4+j+1]     = node[j+1];
        end
      end
      blk_carry = c[(blk * 4 + 4 < N) ? blk * 4 + 4 : N];
    end
  end

  assign sum_next  = p ^ c[N-1:0];
  assign cout_next = c[N];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= cout_next;
    end
  end

`ifdef MCC_ADDER_OVF_EN
  logic ovf_next;

  // For N=1 this reduces to cout ^ cin since c[0] is the carry-in.
  assign ovf_next = c[N] ^ c[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_mcc_adder.sv
// Self-checking bench for mcc_adder at widths 1, 8, 5 and 13 against a+b+cin delayed one cycle.
module tb_mcc_adder;

  logic clk;
  logic rst;

  logic        a1, b1, cin1, sum1, cout1;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, cout8;
  logic [4:0]  a5, b5, sum5;
  logic        cin5, cout5;
  logic [12:0] a13, b13, sum13;
  logic        cin13, cout13;
`ifdef MCC_ADDER_OVF_EN
  logic ovf1, ovf8, ovf5, ovf13;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mcc_adder #(.N(1)) u_n1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1)
`ifdef MCC_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  mcc_adder #(.N(8)) u_n8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8)
`ifdef MCC_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  mcc_adder #(.N(5)) u_n5 (
    .clk(clk), .rst(rst), .a(a5), .b(b5), .cin(cin5), .sum(sum5), .cout(cout5)
`ifdef MCC_ADDER_OVF_EN
    , .ovf(ovf5)
`endif
  );

  mcc_adder #(.N(13)) u_n13 (
    .clk(clk), .rst(rst), .a(a13), .b(b13), .cin(cin13), .sum(sum13), .cout(cout13)
`ifdef MCC_ADDER_OVF_EN
    , .ovf(ovf13)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    a5 = 5'h1F; b5 = 5'h1F; cin5 = 1'b1;
    a13 = 13'h1FFF; b13 = 13'h1FFF; cin13 = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({cout1, sum1, cout8, sum8, cout5, sum5, cout13, sum13} !== '0) begin
        n_bad++;
        $display("FAIL reset edge %0d: got n1=%b%b n8=%b%h n5=%b%h n13=%b%h want all 0", e,
                 cout1, sum1, cout8, sum8, cout5, sum5, cout13, sum13);
      end
`ifdef MCC_ADDER_OVF_EN
      n_cmp++;
      if ({ovf1, ovf8, ovf5, ovf13} !== 4'b0) begin
        n_bad++;
        $display("FAIL reset ovf edge %0d: got %b want 0000", e, {ovf1, ovf8, ovf5, ovf13});
      end
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({cout1, sum1} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset release n1: got cout=%b sum=%b want cout=1 sum=1", cout1, sum1);
    end
  endtask

  // Expected (sum,cout) pairs taken straight from the truth table, in application order.
  task automatic test_n1_table();
    logic [2:0] vin  [8] = '{3'b110, 3'b100, 3'b011, 3'b101, 3'b000, 3'b111, 3'b001, 3'b010};
    logic [1:0] vout [8] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, cin1} = vin[i];
      @(posedge clk); #1;
      n_cmp++;
      if ({sum1, cout1} !== vout[i]) begin
        n_bad++;
        $display("FAIL n1 table %0d (a,b,cin=%b): got sum,cout=%b want %b", i, vin[i],
                 {sum1, cout1}, vout[i]);
      end
    end
  endtask

  task automatic test_n8_directed();
    logic [7:0] va [5] = '{8'hFF, 8'h5A, 8'hFF, 8'h00, 8'h12};
    logic [7:0] vb [5] = '{8'h00, 8'h3C, 8'hFF, 8'h00, 8'h34};
    logic       vc [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] vr [5] = '{9'h100, 9'h096, 9'h1FF, 9'h000, 9'h047};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; cin8 = vc[i];
      @(posedge clk); #1;
      n_cmp++;
      if ({cout8, sum8} !== vr[i]) begin
        n_bad++;
        $display("FAIL n8 directed %0d (%h+%h+%b): got %h want %h", i, va[i], vb[i], vc[i],
                 {cout8, sum8}, vr[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
    #2;
    n_cmp++;
    if ({cout8, sum8} !== 9'h096) begin
      n_bad++;
      $display("FAIL hold between edges: got %h want 096", {cout8, sum8});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({cout8, sum8} !== 9'h003) begin
      n_bad++;
      $display("FAIL hold next edge: got %h want 003", {cout8, sum8});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({cout8, sum8} !== 9'h046) begin
      n_bad++;
      $display("FAIL mid reset pre: got %h want 046", {cout8, sum8});
    end
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({cout8, sum8} !== 9'h000) begin
      n_bad++;
      $display("FAIL mid reset discard: got %h want 000", {cout8, sum8});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({cout8, sum8} !== 9'h1FF) begin
      n_bad++;
      $display("FAIL mid reset release: got %h want 1ff", {cout8, sum8});
    end
  endtask

  // Scoreboard: expected results queued when inputs are applied, popped one edge later.
  task automatic test_random();
    logic [5:0]  q5  [$];
    logic [13:0] q13 [$];
    logic [5:0]  e5;
    logic [13:0] e13;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
      a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
      if (i % 50 == 0) begin
        a13 = 13'h1FFF; b13 = 13'h1FFF - 13'(i);
      end
      q5.push_back(6'(a5) + 6'(b5) + 6'(cin5));
      q13.push_back(14'(a13) + 14'(b13) + 14'(cin13));
      @(posedge clk); #1;
      e5 = q5.pop_front();
      e13 = q13.pop_front();
      n_cmp++;
      if ({cout5, sum5} !== e5) begin
        n_bad++;
        $display("FAIL rand n5 #%0d: got %h want %h", i, {cout5, sum5}, e5);
      end
      n_cmp++;
      if ({cout13, sum13} !== e13) begin
        n_bad++;
        $display("FAIL rand n13 #%0d: got %h want %h", i, {cout13, sum13}, e13);
      end
    end
  endtask

`ifdef MCC_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] va [3] = '{8'h7F, 8'h80, 8'h40};
    logic [7:0] vb [3] = '{8'h01, 8'h80, 8'h3F};
    logic [9:0] vr [3] = '{10'b0_1_1000_0000, 10'b1_1_0000_0000, 10'b0_0_0111_1111};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = va[i]; b8 = vb[i]; cin8 = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({cout8, ovf8, sum8} !== vr[i]) begin
        n_bad++;
        $display("FAIL ovf n8 %0d: got cout,ovf,sum=%b want %b", i, {cout8, ovf8, sum8}, vr[i]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    {a1, b1, cin1, a8, b8, cin8, a5, b5, cin5, a13, b13, cin13} = '0;
    test_reset();
    test_n1_table();
    test_n8_directed();
    test_hold();
    test_mid_reset();
    test_random();
`ifdef MCC_ADDER_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcc_adder.md
MCC_ADDER -- requirements
Module: mcc_adder

Interface
REQ-001 The module SHALL have parameter N, default 1, giving the operand width in bits; legal range 1..64.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and be a synchronous, active-high reset.
REQ-004 Port a SHALL be an input, N bits wide, carrying addend A (unsigned).
REQ-005 Port b SHALL be an input, N bits wide, carrying addend B (unsigned).
REQ-006 Port cin SHALL be an input, 1 bit wide, carrying the carry-in.
REQ-007 Port sum SHALL be an output, N bits wide, carrying the registered sum bits.
REQ-008 Port cout SHALL be an output, 1 bit wide, carrying the registered carry-out.

Function
REQ-009 Per bit i, the module SHALL compute generate g=a&b, propagate p=a^b and kill k=~a&~b.
REQ-010 Carries SHALL be formed by a Manchester carry chain: c[i+1] = g[i] | (p[i] & c[i]), with c[0]=cin.
REQ-011 The chain SHALL be segmented into 4-bit Manchester blocks; each block SHALL pass the carry to the next block.
REQ-012 The last block SHALL be partial when N is not a multiple of 4.
REQ-013 The sum bits SHALL be sum_next[i] = p[i] ^ c[i], and cout_next SHALL be c[N].
REQ-014 {cout_next, sum_next} SHALL equal a + b + cin exactly, modulo 2^(N+1), for every input combination.
REQ-015 On each rising clk edge with rst=0, sum and cout SHALL load sum_next and cout_next. Latency is 1 cycle and throughput is one addition per cycle.
REQ-016 Outputs SHALL hold their value between edges; input changes SHALL NOT affect outputs until the next edge.
REQ-017 Boundary case: with a and b all ones and cin=1, the result SHALL be sum all ones and cout=1.
REQ-018 Boundary case: with all inputs 0, the result SHALL be sum=0 and cout=0.
REQ-019 There SHALL be no handshake; a new operation SHALL be accepted every cycle.

Reset
REQ-020 When rst=1 at a rising clk edge, sum SHALL become 0 and cout SHALL become 0, regardless of a, b and cin.
REQ-021 Reset SHALL take priority over a simultaneous load.
REQ-022 The first result SHALL appear one edge after rst is deasserted.
REQ-023 Asserting rst mid-stream SHALL discard the in-flight result.
REQ-024 Outputs SHALL be 0 from the first reset edge until the first non-reset edge.

Configuration
REQ-025 When macro MCC_ADDER_OVF_EN is defined, the module SHALL add an output port ovf, 1 bit wide, registered with the same 1-cycle latency.
REQ-026 With MCC_ADDER_OVF_EN defined, ovf SHALL be c[N] ^ c[N-1], the two's-complement signed overflow; for N=1 it SHALL be cout ^ cin.
REQ-027 With MCC_ADDER_OVF_EN defined, reset SHALL clear ovf to 0.
REQ-028 When MCC_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 For N=1, a bench SHALL apply all 8 combinations of (a,b,cin), one per cycle, after reset. The required (sum,cout) results are:
- (1,1,0) -> (0,1)
- (1,0,0) -> (1,0)
- (0,1,1) -> (0,1)
- (1,0,1) -> (0,1)
- (0,0,0) -> (0,0)
- (1,1,1) -> (1,1)
- (0,0,1) -> (1,0)
- (0,1,0) -> (1,0)
Each result SHALL appear one edge after its inputs.
REQ-030 Reset check: hold rst=1 with a=1, b=1, cin=1 for 2 edges -> sum=0, cout=0. Deassert rst -> the next edge gives sum=1, cout=1.
REQ-031 For N=8, a full-chain ripple case SHALL be covered: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-032 For N=8, a generate/propagate case SHALL be covered: a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0.
REQ-033 For N=8, a maximum-operand case SHALL be covered: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 For N=8 with MCC_ADDER_OVF_EN defined, a=0x7F, b=0x01, cin=0 SHALL give sum=0x80 and ovf=1.
REQ-035 For N=8 with MCC_ADDER_OVF_EN defined, a=0x80, b=0x80 SHALL give sum=0x00, cout=1 and ovf=1.
REQ-036 For N=5 and N=13, 1000 random vectors per width SHALL be compared against a+b+cin delayed by one cycle, with zero mismatches.
